// File: rtl/instr_rom_server_pkg.sv
// Shared constants, fetch-check result type and the built-in ROM image for instr_rom_server.
// The exception/NOP/boot macros are defined once here, ahead of the design files.
`ifndef INSTR_ROM_SERVER_CONSTANTS
`define INSTR_ROM_SERVER_CONSTANTS
`define EXCEPTION_LEN           4
`define EXC_NONE                4'h0
`define EXC_INSTR_MISALIGNED    4'h1
`define EXC_INSTR_ACCESS_FAULT  4'h2
`define NOP_INSTR               32'h00000013
`define BOOT_ADDR               32'h00001000
`endif

package instr_rom_server_pkg;

    typedef struct packed {
        logic                      fault;
        logic [`EXCEPTION_LEN-1:0] code;
    } fetch_chk_t;

    // Image word i is "addi x1, x0, 5+i"; word 0 is the boot instruction 32'h00500093.
    function automatic logic [31:0] rom_word_f(input logic [31:0] idx);
        logic [31:0] imm;
        imm = idx + 32'd5;
        return {imm[11:0], 20'h00093};
    endfunction

    // Range compare runs at 33 bits so base + span can never wrap.
    function automatic fetch_chk_t fetch_check_f(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [32:0] span
    );
        fetch_chk_t  res;
        logic [32:0] a33;
        logic [32:0] lo33;
        logic [32:0] hi33;
        a33  = {1'b0, addr};
        lo33 = {1'b0, base};
        hi33 = lo33 + span;
        if (addr[1:0] != 2'b00) begin
            res = '{fault: 1'b1, code: `EXC_INSTR_MISALIGNED};
        end else if ((a33 < lo33) || (a33 >= hi33)) begin
            res = '{fault: 1'b1, code: `EXC_INSTR_ACCESS_FAULT};
        end else begin
            res = '{fault: 1'b0, code: `EXC_NONE};
        end
        return res;
    endfunction

endpackage

// File: rtl/instr_rom_array.sv
// Synchronous-read instruction ROM: ROM_WORDS x 32, data register updates only on a read.
module instr_rom_array
    import instr_rom_server_pkg::*;
#(
    parameter int unsigned ROM_WORDS = 1024
) (
    input  logic                         clk,
    input  logic                         rd_en,
    input  logic [$clog2(ROM_WORDS)-1:0] idx,
    output logic [31:0]                  rd_data
);

    logic [31:0] rd_data_q;

    // Read port: capture the addressed word on a read, otherwise hold.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data_q <= rom_word_f(32'(idx));
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_rom_server.sv
// Responder side of the fetch request/valid protocol in front of instr_rom_array.
// Optional macro ROM_FAULT_CHECK_EN builds the misaligned/out-of-range FAULT path.
module instr_rom_server
    import instr_rom_server_pkg::*;
#(
    parameter logic [31:0] ROM_BASE  = `BOOT_ADDR,
    parameter int unsigned ROM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               addr_In,
    input  logic                      inputValid_In,
    output logic [31:0]               instr_Out,
    output logic                      outputValid_Out,
    output logic [`EXCEPTION_LEN-1:0] exception_Out
);

    localparam int unsigned      IDX_W    = $clog2(ROM_WORDS);
    localparam int unsigned      CNT_W    = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2
`ifdef ROM_FAULT_CHECK_EN
        ,
        FAULT = 2'd3
`endif
    } state_e;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   counter_q, counter_d;
    logic [31:0]        instr_q,   instr_d;
    logic               valid_q,   valid_d;
    logic               rd_en_s;
    logic [31:0]        diff_s;
    logic [IDX_W-1:0]   idx_s;
    logic [31:0]        rd_data_s;
    logic               unused_diff_s;

    // Word index wraps modulo ROM_WORDS; out-of-range handling is the fault check's job.
    assign diff_s        = addr_In - ROM_BASE;
    assign idx_s         = diff_s[IDX_W+1:2];
    assign unused_diff_s = ^{diff_s[31:IDX_W+2], diff_s[1:0]};

    instr_rom_array #(
        .ROM_WORDS (ROM_WORDS)
    ) u_array (
        .clk     (clk),
        .rd_en   (rd_en_s),
        .idx     (idx_s),
        .rd_data (rd_data_s)
    );

`ifdef ROM_FAULT_CHECK_EN
    logic [`EXCEPTION_LEN-1:0] exc_q, exc_d;
    logic [`EXCEPTION_LEN-1:0] fault_code_q, fault_code_d;
    fetch_chk_t                chk_s;

    assign chk_s = fetch_check_f(addr_In, ROM_BASE, 33'(ROM_WORDS) << 2);
`endif

    // Next-state and response datapath; outputs are only loaded on the way into RESP.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        instr_d   = instr_q;
        valid_d   = 1'b0;
        rd_en_s   = 1'b0;
`ifdef ROM_FAULT_CHECK_EN
        exc_d        = exc_q;
        fault_code_d = fault_code_q;
`endif
        case (state_q)
            IDLE: begin
                if (inputValid_In) begin
`ifdef ROM_FAULT_CHECK_EN
                    if (chk_s.fault) begin
                        state_d      = FAULT;
                        fault_code_d = chk_s.code;
                    end else begin
`else
                    begin
`endif
                        rd_en_s   = 1'b1;
                        counter_d = CNT_LOAD;
                        state_d   = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!inputValid_In) begin
                    state_d = IDLE;
                end else if (counter_q == CNT_ZERO) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                    instr_d = rd_data_s;
`ifdef ROM_FAULT_CHECK_EN
                    exc_d   = `EXC_NONE;
`endif
                end else begin
                    counter_d = counter_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            // The request still seen high here is the client consuming the pulse.
            RESP: begin
                state_d = IDLE;
            end
`ifdef ROM_FAULT_CHECK_EN
            FAULT: begin
                state_d = RESP;
                valid_d = 1'b1;
                instr_d = `NOP_INSTR;
                exc_d   = fault_code_q;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= CNT_ZERO;
            instr_q   <= `NOP_INSTR;
            valid_q   <= 1'b0;
`ifdef ROM_FAULT_CHECK_EN
            exc_q        <= `EXC_NONE;
            fault_code_q <= `EXC_NONE;
`endif
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
`ifdef ROM_FAULT_CHECK_EN
            exc_q        <= exc_d;
            fault_code_q <= fault_code_d;
`endif
        end
    end

    assign instr_Out       = instr_q;
    assign outputValid_Out = valid_q;
`ifdef ROM_FAULT_CHECK_EN
    assign exception_Out   = exc_q;
`else
    assign exception_Out   = `EXC_NONE;
`endif

endmodule

// File: tb/tb_instr_rom_server.sv
// Scoreboard bench for instr_rom_server: the driver queues expected responses,
// a negedge monitor pops and checks each valid pulse (data, code and arrival cycle).
module tb_instr_rom_server;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam int          LAT    = 2;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [3:0]  E_NONE = 4'h0;
    localparam logic [3:0]  E_MIS  = 4'h1;
    localparam logic [3:0]  E_ACC  = 4'h2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        req;
    logic [31:0] instr;
    logic        valid;
    logic [3:0]  exc;

    logic [31:0] image [8] = '{32'h00500093, 32'h00600093, 32'h00700093, 32'h00800093,
                               32'h00900093, 32'h00A00093, 32'h00B00093, 32'h00C00093};

    typedef struct {
        int          cyc;
        logic [31:0] instr;
        logic [3:0]  exc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    instr_rom_server dut (
        .clk             (clk),
        .rst             (rst),
        .addr_In         (addr),
        .inputValid_In   (req),
        .instr_Out       (instr),
        .outputValid_Out (valid),
        .exception_Out   (exc)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            chk("no_back_to_back_valid", 64'(prev_valid), 64'd0);
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid actual=1 required=0 instr=%h", instr);
            end else begin
                e = q.pop_front();
                chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
                chk({e.name, "_instr"}, 64'(instr), 64'(e.instr));
                chk({e.name, "_exc"}, 64'(exc), 64'(e.exc));
            end
        end
        prev_valid <= valid;
    end

    // Fetch-stage style request: hold until valid, then drop.
    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic [3:0] ee,
                         input int lat, input string nm);
        int t;
        bit seen;
        @(negedge clk);
        addr = a;
        req  = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        q.push_back('{t + lat, ei, ee, nm});
        addr = ~a;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        req = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_valid required=valid", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        req  = 1'b0;
        addr = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_instr", 64'(instr), 64'(NOP));
        chk("reset_exc", 64'(exc), 64'(E_NONE));
        rst = 1'b0;

        fetch(BASE, 32'h00500093, E_NONE, LAT, "boot");
        repeat (2) @(negedge clk);
        chk("hold_instr", 64'(instr), 64'(32'h00500093));

        for (int w = 0; w < 8; w++) begin
            fetch(BASE + 32'(4 * w), image[w], E_NONE, LAT, $sformatf("loop_w%0d", w));
        end

        @(negedge clk);
        addr = BASE + 32'd4;
        req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(negedge clk);
        fetch(BASE + 32'd8, 32'h00700093, E_NONE, LAT, "after_abort");

`ifdef ROM_FAULT_CHECK_EN
        fetch(BASE + 32'd2, NOP, E_MIS, 1, "misaligned");
        fetch(BASE + 32'd4096, NOP, E_ACC, 1, "past_end");
        fetch(BASE - 32'd4, NOP, E_ACC, 1, "below_base");
        fetch(BASE + 32'd4094, NOP, E_MIS, 1, "mis_priority");
        fetch(BASE + 32'd4092, 32'h00500093 + (32'd1023 << 20), E_NONE, LAT, "last_word");
`else
        fetch(BASE + 32'd4096, 32'h00500093, E_NONE, LAT, "wrap_word0");
        fetch(BASE + 32'd6, 32'h00600093, E_NONE, LAT, "low_bits_ignored");
`endif

        @(negedge clk);
        addr = BASE + 32'd12;
        req  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset_valid", 64'(valid), 64'd0);
        chk("midreset_instr", 64'(instr), 64'(NOP));
        chk("midreset_exc", 64'(exc), 64'(E_NONE));
        rst = 1'b0;
        repeat (4) @(negedge clk);
        fetch(BASE + 32'd16, 32'h00900093, E_NONE, LAT, "after_reset");

        repeat (6) @(negedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
